// File: rtl/alu_pkg.sv
// alu_pkg: shared constants and types for the ACC/MR arithmetic stage.
// Holds opcode values, control-word bit positions, flag bit positions,
// the multiplier FSM state type and small control-word decode helpers.
package alu_pkg;

    localparam int unsigned CTRL_W = 32;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned FLAG_W = 4;

    // Control-word bit positions
    localparam int unsigned BR_LOAD   = 7;
    localparam int unsigned ALU_GO    = 8;
    localparam int unsigned ALU_OP_LO = 9;
    localparam int unsigned ALU_OP_HI = 12;

    // Flag bit positions within the 4-bit flags bus
    localparam int unsigned FLAG_Z = 3;
    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    // Opcodes; 10..15 decode as NOP
    localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
    localparam logic [OP_W-1:0] OP_AND  = 4'd2;
    localparam logic [OP_W-1:0] OP_OR   = 4'd3;
    localparam logic [OP_W-1:0] OP_NOT  = 4'd4;
    localparam logic [OP_W-1:0] OP_SHL  = 4'd5;
    localparam logic [OP_W-1:0] OP_SHR  = 4'd6;
    localparam logic [OP_W-1:0] OP_LOAD = 4'd7;
    localparam logic [OP_W-1:0] OP_CLR  = 4'd8;
    localparam logic [OP_W-1:0] OP_MPY  = 4'd9;

    // Condition flags, packed so that z lands on bit 3 and v on bit 0
    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
    } flags_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } mul_state_e;

    // Extract the ALU opcode field from a microinstruction word
    function automatic logic [OP_W-1:0] alu_op_of(input logic [CTRL_W-1:0] cw);
        return cw[ALU_OP_HI:ALU_OP_LO];
    endfunction

    // Extract the ALU_GO strobe from a microinstruction word
    function automatic logic alu_go_of(input logic [CTRL_W-1:0] cw);
        return cw[ALU_GO];
    endfunction

endpackage : alu_pkg

// File: rtl/alu_acc_mul_seq.sv
// mul_seq: sequential unsigned shift-add multiplier, one step per cycle.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   start         begin a multiply (ignored while busy)
//   a             multiplicand, latched on start
//   b             multiplier, latched on start
//   busy          high from the cycle after start until the final step
//   done          high during the cycle whose edge performs the final step
//   product       product as it will be after the current step; valid with done
module mul_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned MUL_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    mul_state_e         state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     step_sum;
    logic [WIDTH-1:0]   step_hi;
    logic [WIDTH-1:0]   step_lo;

    // One right-shift step: conditionally add the multiplicand into the high
    // half, then shift {carry, hi, lo} right; lo drains the multiplier bits.
    always_comb begin
        addend   = lo_q[0] ? mcand_q : '0;
        step_sum = {1'b0, hi_q} + {1'b0, addend};
        step_hi  = step_sum[WIDTH:1];
        step_lo  = {step_sum[0], lo_q[WIDTH-1:1]};
    end

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        count_d = count_q;
        done    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_MUL;
                    mcand_d = a;
                    lo_d    = b;
                    hi_d    = '0;
                    count_d = CNT_W'(MUL_CYCLES - 1);
                end
            end
            ST_MUL: begin
                hi_d = step_hi;
                lo_d = step_lo;
                if (count_q == '0) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    count_d = count_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy    = (state_q == ST_MUL);
    assign product = {step_hi, step_lo};

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mcand_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            count_q <= count_d;
        end
    end

endmodule : mul_seq

// File: rtl/alu_acc.sv
// alu_acc: accumulator ALU stage fed by the BR buffer register.
// Combines ACC with from_BR under control-word bits ALU_GO / ALU_OP and keeps
// the result in ACC, the multiply high half in MR and registered Z/N/C/V flags.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   control_signal  microinstruction word ([8] ALU_GO, [12:9] ALU_OP)
//   from_BR         operand from BR
//   to_MBR          current ACC
//   mr_out          current MR
//   flags           {Z, N, C, V}
//   busy            multiply in progress; control_signal ignored meanwhile
module alu_acc
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned MUL_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CTRL_W-1:0]    control_signal,
    input  logic [WIDTH-1:0]     from_BR,
    output logic [WIDTH-1:0]     to_MBR,
    output logic [WIDTH-1:0]     mr_out,
    output logic [FLAG_W-1:0]    flags,
    output logic                 busy
);

    localparam int unsigned MSB = WIDTH - 1;

    logic [WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]     mr_q, mr_d;
    flags_t               flags_q, flags_d;

    logic                 alu_go;
    logic [OP_W-1:0]      alu_op;
    logic [WIDTH:0]       sum_ext;
    logic [WIDTH:0]       diff_ext;
    logic                 writes_acc;

    logic                 mul_start;
    logic                 mul_busy;
    logic                 mul_done;
    logic [2*WIDTH-1:0]   mul_product;

    // Bits owned by BR or reserved; collected so they read as intentionally unused
    logic unused_ctrl;
    assign unused_ctrl = ^{control_signal[CTRL_W-1:ALU_OP_HI+1], control_signal[ALU_GO-1:0]};

    assign alu_go = alu_go_of(control_signal);
    assign alu_op = alu_op_of(control_signal);

    // Multiplier: multiplicand from BR, multiplier from ACC
    mul_seq #(
        .WIDTH      (WIDTH),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul_seq (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (from_BR),
        .b       (acc_q),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    // Result and flag selection
    always_comb begin
        acc_d      = acc_q;
        mr_d       = mr_q;
        flags_d    = flags_q;
        mul_start  = 1'b0;
        writes_acc = 1'b0;
        sum_ext    = {1'b0, acc_q} + {1'b0, from_BR};
        diff_ext   = {1'b0, acc_q} - {1'b0, from_BR};

        if (mul_done) begin
            // Commit the full product; flags describe the 32-bit result
            acc_d     = mul_product[WIDTH-1:0];
            mr_d      = mul_product[2*WIDTH-1:WIDTH];
            flags_d.z = (mul_product == '0);
            flags_d.n = mul_product[2*WIDTH-1];
            flags_d.c = (mul_product[2*WIDTH-1:WIDTH] != '0);
            flags_d.v = 1'b0;
        end else if (alu_go && !mul_busy) begin
            case (alu_op)
                OP_ADD: begin
                    acc_d      = sum_ext[WIDTH-1:0];
                    writes_acc = 1'b1;
                    flags_d.c  = sum_ext[WIDTH];
                    flags_d.v  = (acc_q[MSB] == from_BR[MSB]) && (sum_ext[MSB] != acc_q[MSB]);
                end
                OP_SUB: begin
                    // C is "no borrow", so it is the inverse of the extended sign bit
                    acc_d      = diff_ext[WIDTH-1:0];
                    writes_acc = 1'b1;
                    flags_d.c  = ~diff_ext[WIDTH];
                    flags_d.v  = (acc_q[MSB] != from_BR[MSB]) && (diff_ext[MSB] != acc_q[MSB]);
                end
                OP_AND: begin
                    acc_d      = acc_q & from_BR;
                    writes_acc = 1'b1;
                end
                OP_OR: begin
                    acc_d      = acc_q | from_BR;
                    writes_acc = 1'b1;
                end
                OP_NOT: begin
                    acc_d      = ~acc_q;
                    writes_acc = 1'b1;
                end
                OP_SHL: begin
                    acc_d      = {acc_q[MSB-1:0], 1'b0};
                    writes_acc = 1'b1;
                    flags_d.c  = acc_q[MSB];
                end
                OP_SHR: begin
                    acc_d      = {1'b0, acc_q[MSB:1]};
                    writes_acc = 1'b1;
                    flags_d.c  = acc_q[0];
                end
                OP_LOAD: begin
                    acc_d      = from_BR;
                    writes_acc = 1'b1;
                end
                OP_CLR: begin
                    acc_d      = '0;
                    mr_d       = '0;
                    writes_acc = 1'b1;
                    flags_d.c  = 1'b0;
                    flags_d.v  = 1'b0;
                end
                OP_MPY: begin
                    mul_start = 1'b1;
                end
                default: begin
                end
            endcase

            // Z and N always track the freshly written ACC
            if (writes_acc) begin
                flags_d.z = (acc_d == '0);
                flags_d.n = acc_d[MSB];
            end
        end
    end

    // Architectural registers
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q   <= '0;
            mr_q    <= '0;
            flags_q <= '0;
        end else begin
            acc_q   <= acc_d;
            mr_q    <= mr_d;
            flags_q <= flags_d;
        end
    end

    assign to_MBR = acc_q;
    assign mr_out = mr_q;
    assign flags  = flags_q;
    assign busy   = mul_busy;

endmodule : alu_acc

// File: tb/tb_alu_acc.sv
// tb_alu_acc: table-driven and sequence checks for alu_acc with a queue scoreboard.
module tb_alu_acc;
    import alu_pkg::*;

    localparam int unsigned W = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   control_signal;
    logic [W-1:0]  from_BR;
    logic [W-1:0]  to_MBR;
    logic [W-1:0]  mr_out;
    logic [3:0]    flags;
    logic          busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_acc #(.WIDTH(W), .MUL_CYCLES(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .control_signal (control_signal),
        .from_BR        (from_BR),
        .to_MBR         (to_MBR),
        .mr_out         (mr_out),
        .flags          (flags),
        .busy           (busy)
    );

    typedef struct {
        logic          go;
        logic [3:0]    op;
        logic [15:0]   br;
        logic [15:0]   acc;
        logic [15:0]   mr;
        logic [3:0]    fl;
    } vec_t;

    typedef struct {
        string         name;
        logic [15:0]   acc;
        logic [15:0]   mr;
        logic [3:0]    fl;
        logic          bsy;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[$];

    // Control word with BR_LOAD and junk upper bits set; the ALU must ignore them
    function automatic logic [31:0] ctl(input logic go, input logic [3:0] op);
        logic [31:0] c;
        c = 32'hA5A5_0000;
        c[BR_LOAD] = 1'b1;
        c[ALU_GO] = go;
        c[ALU_OP_HI:ALU_OP_LO] = op;
        return c;
    endfunction

    task automatic push_exp(input string name, input logic [15:0] acc, input logic [15:0] mr,
                            input logic [3:0] fl, input logic bsy);
        exp_t e;
        e.name = name;
        e.acc  = acc;
        e.mr   = mr;
        e.fl   = fl;
        e.bsy  = bsy;
        sb_q.push_back(e);
    endtask

    task automatic check_pop();
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: no expectation queued");
            return;
        end
        e = sb_q.pop_front();
        if (to_MBR !== e.acc || mr_out !== e.mr || flags !== e.fl || busy !== e.bsy) begin
            errors++;
            $display("FAIL %s: got acc=%h mr=%h flags=%b busy=%b, expected acc=%h mr=%h flags=%b busy=%b",
                     e.name, to_MBR, mr_out, flags, busy, e.acc, e.mr, e.fl, e.bsy);
        end
    endtask

    task automatic step(input logic go, input logic [3:0] op, input logic [15:0] br);
        control_signal = ctl(go, op);
        from_BR = br;
        @(posedge clk);
        #1;
    endtask

    // Full multiply: start, optional ADD poking during busy, busy-length and commit checks
    task automatic run_mpy(input string name, input logic [15:0] br,
                           input logic [15:0] pre_acc, input logic [15:0] pre_mr, input logic [3:0] pre_f,
                           input logic [15:0] exp_acc, input logic [15:0] exp_mr, input logic [3:0] exp_f,
                           input logic poke);
        int busy_cnt;
        int guard;
        busy_cnt = 0;
        guard = 0;
        step(1'b1, OP_MPY, br);
        control_signal = poke ? ctl(1'b1, OP_ADD) : ctl(1'b0, OP_MPY);
        from_BR = poke ? 16'h0001 : br;
        push_exp({name, "_start"}, pre_acc, pre_mr, pre_f, 1'b1);
        check_pop();
        while (busy === 1'b1 && guard < 40) begin
            busy_cnt++;
            guard++;
            if (busy_cnt == 8) begin
                push_exp({name, "_hold"}, pre_acc, pre_mr, pre_f, 1'b1);
                check_pop();
            end
            @(posedge clk);
            #1;
        end
        control_signal = ctl(1'b0, OP_ADD);
        checks++;
        if (busy_cnt != 16) begin
            errors++;
            $display("FAIL %s_busy_len: got %0d cycles, expected 16", name, busy_cnt);
        end
        push_exp({name, "_commit"}, exp_acc, exp_mr, exp_f, 1'b0);
        check_pop();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        control_signal = '0;
        from_BR = '0;

        // Single-cycle op table: {go, op, br, acc, mr, flags ZNCV}
        vecs.push_back('{1'b1, OP_LOAD, 16'h7FFF, 16'h7FFF, 16'h0000, 4'b0000});
        vecs.push_back('{1'b1, OP_ADD,  16'h0001, 16'h8000, 16'h0000, 4'b0101});
        vecs.push_back('{1'b1, OP_LOAD, 16'h0005, 16'h0005, 16'h0000, 4'b0001});
        vecs.push_back('{1'b1, OP_SUB,  16'h0005, 16'h0000, 16'h0000, 4'b1010});
        vecs.push_back('{1'b1, OP_SUB,  16'h0001, 16'hFFFF, 16'h0000, 4'b0100});
        vecs.push_back('{1'b1, OP_LOAD, 16'h8001, 16'h8001, 16'h0000, 4'b0100});
        vecs.push_back('{1'b1, OP_SHL,  16'h0000, 16'h0002, 16'h0000, 4'b0010});
        vecs.push_back('{1'b1, OP_SHR,  16'h0000, 16'h0001, 16'h0000, 4'b0000});
        vecs.push_back('{1'b1, 4'd12,   16'hBEEF, 16'h0001, 16'h0000, 4'b0000});
        vecs.push_back('{1'b1, OP_LOAD, 16'hF0F0, 16'hF0F0, 16'h0000, 4'b0100});
        vecs.push_back('{1'b1, OP_AND,  16'h0FF0, 16'h00F0, 16'h0000, 4'b0000});
        vecs.push_back('{1'b1, OP_OR,   16'h0F00, 16'h0FF0, 16'h0000, 4'b0000});
        vecs.push_back('{1'b1, OP_NOT,  16'h1234, 16'hF00F, 16'h0000, 4'b0100});
        vecs.push_back('{1'b1, OP_ADD,  16'hFFFF, 16'hF00E, 16'h0000, 4'b0110});
        vecs.push_back('{1'b1, 4'd15,   16'h1234, 16'hF00E, 16'h0000, 4'b0110});
        vecs.push_back('{1'b1, OP_ADD,  16'h0FF2, 16'h0000, 16'h0000, 4'b1010});
        vecs.push_back('{1'b1, OP_SUB,  16'h8000, 16'h8000, 16'h0000, 4'b0101});
        vecs.push_back('{1'b0, OP_ADD,  16'h0001, 16'h8000, 16'h0000, 4'b0101});
        vecs.push_back('{1'b1, OP_SUB,  16'h0001, 16'h7FFF, 16'h0000, 4'b0011});
        vecs.push_back('{1'b1, 4'd10,   16'h0001, 16'h7FFF, 16'h0000, 4'b0011});
        vecs.push_back('{1'b1, OP_CLR,  16'h5555, 16'h0000, 16'h0000, 4'b1000});

        repeat (2) @(posedge clk);
        #1;
        push_exp("reset", 16'h0000, 16'h0000, 4'b0000, 1'b0);
        check_pop();
        rst = 1'b0;

        foreach (vecs[i]) begin
            push_exp($sformatf("vec%0d", i), vecs[i].acc, vecs[i].mr, vecs[i].fl, 1'b0);
            step(vecs[i].go, vecs[i].op, vecs[i].br);
            check_pop();
        end

        // 0xFFFF * 0xFFFF with ADD strobed throughout busy, including the commit edge
        push_exp("mpyA_load", 16'hFFFF, 16'h0000, 4'b0100, 1'b0);
        step(1'b1, OP_LOAD, 16'hFFFF);
        check_pop();
        run_mpy("mpyA", 16'hFFFF, 16'hFFFF, 16'h0000, 4'b0100,
                16'h0001, 16'hFFFE, 4'b0110, 1'b1);
        push_exp("mpyA_after", 16'h0001, 16'hFFFE, 4'b0110, 1'b0);
        step(1'b0, OP_ADD, 16'h0001);
        check_pop();

        // Reset at step 8 aborts the multiply and clears everything
        push_exp("mpyB_load", 16'h0003, 16'hFFFE, 4'b0010, 1'b0);
        step(1'b1, OP_LOAD, 16'h0003);
        check_pop();
        push_exp("mpyB_start", 16'h0003, 16'hFFFE, 4'b0010, 1'b1);
        step(1'b1, OP_MPY, 16'h0004);
        check_pop();
        control_signal = ctl(1'b0, OP_MPY);
        repeat (7) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        push_exp("mpyB_abort", 16'h0000, 16'h0000, 4'b0000, 1'b0);
        step(1'b0, OP_MPY, 16'h0004);
        check_pop();
        rst = 1'b0;
        push_exp("mpyB_idle", 16'h0000, 16'h0000, 4'b0000, 1'b0);
        step(1'b0, OP_MPY, 16'h0004);
        check_pop();

        // Rerun after the abort
        push_exp("mpyB2_load", 16'h0003, 16'h0000, 4'b0000, 1'b0);
        step(1'b1, OP_LOAD, 16'h0003);
        check_pop();
        run_mpy("mpyB2", 16'h0004, 16'h0003, 16'h0000, 4'b0000,
                16'h000C, 16'h0000, 4'b0000, 1'b0);

        // Zero product, then an ADD accepted on the first cycle after busy falls
        push_exp("mpyC_load", 16'h0000, 16'h0000, 4'b1000, 1'b0);
        step(1'b1, OP_LOAD, 16'h0000);
        check_pop();
        run_mpy("mpyC", 16'h1234, 16'h0000, 16'h0000, 4'b1000,
                16'h0000, 16'h0000, 4'b1000, 1'b0);
        push_exp("mpyC_add", 16'h0005, 16'h0000, 4'b0000, 1'b0);
        step(1'b1, OP_ADD, 16'h0005);
        check_pop();

        // Product with MR nonzero but bit 31 clear, then CLR wipes MR
        push_exp("mpyD_load", 16'hFFFF, 16'h0000, 4'b0100, 1'b0);
        step(1'b1, OP_LOAD, 16'hFFFF);
        check_pop();
        run_mpy("mpyD", 16'h0002, 16'hFFFF, 16'h0000, 4'b0100,
                16'hFFFE, 16'h0001, 4'b0010, 1'b0);
        push_exp("clr_mr", 16'h0000, 16'h0000, 4'b1000, 1'b0);
        step(1'b1, OP_CLR, 16'h0000);
        check_pop();

        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d entries, expected 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_alu_acc
